// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write port, packed read ports, scoreboard issue
// and the clear-complete indication.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     ready;

    modport master (
        output we, wa, wd, ra, issue_en, issue_addr,
        input  rd, rd_busy, ready
    );

    modport slave (
        input  we, wa, wd, ra, issue_en, issue_addr,
        output rd, rd_busy, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard. x0 reads zero; after
// reset a clear sequence zeroes x1..xN before writes and reads are honoured.

module regfile_sb_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic                          i_run,
    input  logic [ADDR_W-1:0]             i_ra,
    input  logic                          i_we,
    input  logic [ADDR_W-1:0]             i_wa,
    input  logic [DATA_W-1:0]             i_wd,
    input  logic                          i_issue_en,
    input  logic [ADDR_W-1:0]             i_issue_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  i_mem,
    input  logic [DEPTH-1:0]              i_busy,
    output logic [DATA_W-1:0]             o_rd,
    output logic                          o_busy
);
    logic w_hit;
    logic w_reissue;

    assign w_hit     = i_we && (i_wa == i_ra) && (i_ra != '0);
    assign w_reissue = i_issue_en && (i_issue_addr == i_ra);

    always_comb begin
        o_rd   = '0;
        o_busy = 1'b0;
        if (i_run && (i_ra != '0)) begin
            o_rd   = (BYPASS != 0 && w_hit) ? i_wd : i_mem[i_ra];
            o_busy = i_busy[i_ra];
            // A clearing write seen this cycle releases the hazard early,
            // unless a new producer is being issued to the same register.
            if (BYPASS != 0 && w_hit && !w_reissue)
                o_busy = 1'b0;
        end
    end
endmodule

module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                          r_state, w_state_nxt;
    logic [ADDR_W-1:0]               r_clr_idx, w_clr_idx_nxt;
    logic                            w_clr_we;
    logic                            w_run;
    logic                            w_wr_en;
    logic [DEPTH-1:0][DATA_W-1:0]    r_mem;
    logic [DEPTH-1:0]                r_busy, w_busy_nxt;
    logic [NUM_RD-1:0][DATA_W-1:0]   w_rd;
    logic [NUM_RD-1:0]               w_rd_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= ADDR_W'(1);
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                if (r_clr_idx == LAST_IDX)
                    w_state_nxt = S_RUN;
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    assign w_run     = (r_state == S_RUN);
    assign bus.ready = w_run;
    assign w_wr_en   = w_run && bus.we && (bus.wa != '0);

    // Storage has no reset; the clear sequence owns initialisation.
    always_ff @(posedge clk) begin
        if (w_clr_we)
            r_mem[r_clr_idx] <= '0;
        else if (w_wr_en)
            r_mem[bus.wa] <= bus.wd;
    end

    // Issue is applied after the write-clear so a colliding set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_run) begin
            if (bus.we)
                w_busy_nxt[bus.wa] = 1'b0;
            if (bus.issue_en)
                w_busy_nxt[bus.issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        regfile_sb_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS)
        ) u_rdport (
            .i_run        (w_run),
            .i_ra         (bus.ra[gi*ADDR_W +: ADDR_W]),
            .i_we         (bus.we),
            .i_wa         (bus.wa),
            .i_wd         (bus.wd),
            .i_issue_en   (bus.issue_en),
            .i_issue_addr (bus.issue_addr),
            .i_mem        (r_mem),
            .i_busy       (r_busy),
            .o_rd         (w_rd[gi]),
            .o_busy       (w_rd_busy[gi])
        );
    end

    assign bus.rd      = w_rd;
    assign bus.rd_busy = w_rd_busy;
endmodule
